lc3_int_ctrl: RTL

- Programmable interrupt controller for the LC3 core.
- Latches rising edges on device interrupt lines (buttons, I2C master, timer) and arbitrates among the pending sources by a per-source 3-bit priority.
- Raises INT toward the control FSM when the winning priority exceeds the current PSR priority, and presents the winner's priority and 8-bit vector.
- Clears the winner on the FSM's acknowledge. Configured through a small register port driven by the memory block's device decode.

---
 rtl/lc3_int_ctrl.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_int_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_int_ctrl
//
// Programmable interrupt controller for the LC3 core. Rising edges on the
// device interrupt lines are latched into a pending register, the pending and
// enabled sources are arbitrated by a per-source 3-bit priority, and the
// winner is presented to the control FSM when its priority beats the current
// PSR priority. The FSM's acknowledge clears the winner's pending bit.
//
// Parameters:
//   N_SRC     number of interrupt sources (1..6)
//   VEC_BASE  vector of source 0; source i is presented as VEC_BASE+i (mod 256)
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   irq_req       device interrupt lines, rising-edge triggered
//   psr_priority  current PSR[10:8] from the CPU
//   int_ack       one-cycle pulse from the FSM when it takes the interrupt
//   cfg_we        configuration write strobe
//   cfg_addr      configuration register select
//                   0           enable mask (R/W)
//                   1           pending (read; write-1-to-clear)
//                   2..N_SRC+1  priority of source addr-2 in bits [2:0] (R/W)
//                   others      read as 0, writes ignored
//   cfg_wdata     configuration write data
//   cfg_rdata     configuration read data, registered (one cycle after addr)
//   INT           interrupt request to the FSM
//   INT_Priority  priority of the presented interrupt
//   int_vector    vector of the presented interrupt
//
// Build option:
//   LC3_INT_SYNC_EN  when defined, irq_req passes through a 2-flop
//                    synchronizer before edge detection (INT latency grows
//                    from 2 to 4 clocks). When undefined the lines must
//                    already be synchronous to clk.
// ---------------------------------------------------------------------------
module lc3_int_ctrl #(
    parameter int         N_SRC    = 4,
    parameter logic [7:0] VEC_BASE = 8'h80
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_req,
    input  logic [2:0]       psr_priority,
    input  logic             int_ack,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    output logic [15:0]      cfg_rdata,
    output logic             INT,
    output logic [2:0]       INT_Priority,
    output logic [7:0]       int_vector
);

    // Source indices fit in 3 bits for up to 6 sources.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK
    } state_t;

    // Internal state
    logic [N_SRC-1:0] irqIn;
    logic [N_SRC-1:0] irqPrev_q;
    logic [N_SRC-1:0] irqEdge;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] enable_q;
    logic [N_SRC-1:0] enable_d;
    logic [2:0]       prio_q [N_SRC];

    state_t           state_q;
    logic [IDX_W-1:0] winIdx_q;
    logic             int_q;
    logic [2:0]       intPrio_q;
    logic [7:0]       intVec_q;
    logic [15:0]      cfgRdata_q;
    logic [15:0]      cfgRdata_d;

    // Decoded control
    logic             wrEnable;
    logic             wrPending;
    logic [N_SRC-1:0] winMask;
    logic [N_SRC-1:0] ackClr;
    logic [N_SRC-1:0] w1cClr;
    logic [N_SRC-1:0] eligible;
    logic             anyElig;
    logic [IDX_W-1:0] arbIdx;
    logic [2:0]       arbPrio;
    logic             withdraw;

    // Only the low bits of the write data are ever stored.
    logic             unusedWdata;
    assign unusedWdata = ^cfg_wdata;

`ifdef LC3_INT_SYNC_EN
    // Two-flop synchronizer for asynchronous device lines. Resetting to 0
    // means a line already high at reset release still produces an edge.
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_req;
            sync2_q <= sync1_q;
        end
    end

    assign irqIn = sync2_q;
`else
    assign irqIn = irq_req;
`endif

    // Edge history resets to 0 so that a line held high through reset
    // counts as a fresh rising edge on the first clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irqPrev_q <= '0;
        end else begin
            irqPrev_q <= irqIn;
        end
    end

    assign irqEdge   = irqIn & ~irqPrev_q;
    assign wrEnable  = cfg_we && (cfg_addr == 3'd0);
    assign wrPending = cfg_we && (cfg_addr == 3'd1);

    // One-hot view of the frozen winner, used for clearing and withdrawal.
    always_comb begin
        winMask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            winMask[i] = (winIdx_q == IDX_W'(i));
        end
    end

    // Clears only ever come from an ack in REQ or a W1C write. New edges are
    // OR-ed in afterwards so a set always beats a simultaneous clear.
    assign ackClr    = ((state_q == ST_REQ) && int_ack) ? winMask : '0;
    assign w1cClr    = wrPending ? cfg_wdata[N_SRC-1:0] : '0;
    assign pending_d = (pending_q & ~(ackClr | w1cClr)) | irqEdge;
    assign enable_d  = wrEnable ? cfg_wdata[N_SRC-1:0] : enable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            enable_q  <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
        end
    end

    // Priority registers. A write during REQ does not disturb the presented
    // interrupt because its priority was captured into intPrio_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                prio_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (cfg_we && (cfg_addr == 3'(i + 2))) begin
                    prio_q[i] <= cfg_wdata[2:0];
                end
            end
        end
    end

    // Eligibility: pending, enabled and strictly above the PSR priority,
    // so a source programmed with priority 0 can never interrupt.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > psr_priority);
        end
    end

    // Arbitration scans upward and only replaces the candidate on a strictly
    // higher priority, which gives ties to the lowest index.
    always_comb begin
        anyElig = 1'b0;
        arbIdx  = '0;
        arbPrio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i] && (!anyElig || (prio_q[i] > arbPrio))) begin
                anyElig = 1'b1;
                arbIdx  = IDX_W'(i);
                arbPrio = prio_q[i];
            end
        end
    end

    // The request is withdrawn when a config write removes the winner's
    // enable or pending bit. Looking at next-state values means a W1C that
    // coincides with a new edge on the winner does not withdraw it.
    assign withdraw = |(winMask & ~(enable_d & pending_d));

    // Request FSM with registered outputs. The winner is frozen in REQ; the
    // ACK state inserts the mandatory low cycle before re-arbitration in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            winIdx_q  <= '0;
            int_q     <= 1'b0;
            intPrio_q <= '0;
            intVec_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (anyElig) begin
                        state_q   <= ST_REQ;
                        winIdx_q  <= arbIdx;
                        int_q     <= 1'b1;
                        intPrio_q <= arbPrio;
                        intVec_q  <= VEC_BASE + 8'(arbIdx);
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_q <= ST_ACK;
                        int_q   <= 1'b0;
                    end else if (withdraw) begin
                        state_q <= ST_IDLE;
                        int_q   <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    int_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    int_q   <= 1'b0;
                end
            endcase
        end
    end

    // Configuration read mux; unmapped addresses return 0.
    always_comb begin
        cfgRdata_d = '0;
        if (cfg_addr == 3'd0) begin
            cfgRdata_d[N_SRC-1:0] = enable_q;
        end else if (cfg_addr == 3'd1) begin
            cfgRdata_d[N_SRC-1:0] = pending_q;
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (cfg_addr == 3'(i + 2)) begin
                cfgRdata_d[2:0] = prio_q[i];
            end
        end
    end

    // Read data is registered every cycle, so it trails the address by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfgRdata_q <= '0;
        end else begin
            cfgRdata_q <= cfgRdata_d;
        end
    end

    assign cfg_rdata    = cfgRdata_q;
    assign INT          = int_q;
    assign INT_Priority = intPrio_q;
    assign int_vector   = intVec_q;

endmodule
